uart_rx_framer: RTL and testbench

- Consumes the synchronised, idle-high RX line and turns it into bytes. The upstream synchroniser flop powers up to 1, so the line reads idle.
- Oversamples the line with an external tick and majority-votes each bit.
- Frames start/data/stop bits and hands completed bytes downstream on a valid/ready interface.
- Sits between the RX input synchroniser and the UART receive buffer/register file.

---
 rtl/uart_rx_framer.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// ----------------------------------------------------------------------------
// uart_rx_framer
//
// Turns the synchronised, idle-high UART RX line into data words. The line is
// sampled only on tick_i pulses (OVERSAMPLE per bit period). Each bit is taken
// as the majority of three samples around mid-bit. Completed words are handed
// downstream on a valid/ready interface.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active low
//   tick_i       one-clk pulse at OVERSAMPLE x baud; all line sampling uses it
//   rxd_i        synchronised RX line, idle high
//   data_o       received word, LSB-first on the line; stable while valid_o=1
//   valid_o      data_o holds an undelivered word
//   ready_i      consumer accepts the word when valid_o and ready_i are both 1
//   frame_err_o  one-clk pulse: stop bit voted 0
//   overrun_o    one-clk pulse: a word completed while the previous one was
//                still undelivered (the new word is dropped)
//   busy_o       receiver is inside a frame, or waiting for the line to idle
// ----------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int OVERSAMPLE = 16,  // ticks per bit, even and >= 4
    parameter int DATA_BITS  = 8    // data bits per frame, 5..9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int M    = OVERSAMPLE / 2;
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);

    localparam logic [SC_W-1:0] SC_EARLY = SC_W'(M - 1);
    localparam logic [SC_W-1:0] SC_MID   = SC_W'(M);
    localparam logic [SC_W-1:0] SC_DEC   = SC_W'(M + 1);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SC_W-1:0]        sc_q, sc_d;
    logic [BC_W-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             samp_q, samp_d;   // [0]: sample at M-1, [1]: at M
    logic                   vote;
    logic                   dec;
    logic                   deliver;
    logic                   frame_err;

    // The third sample is the live line value on the decision tick itself.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_i) | (samp_q[1] & rxd_i);
    assign dec  = (sc_q == SC_DEC);

    assign busy_o = (state_q != S_IDLE);

    // ------------------------------------------------------------------------
    // Next-state logic. Nothing but the handshake moves on non-tick cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        sc_d      = sc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        deliver   = 1'b0;
        frame_err = 1'b0;

        if (tick_i) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
            if (sc_q == SC_EARLY) samp_d[0] = rxd_i;
            if (sc_q == SC_MID)   samp_d[1] = rxd_i;

            unique case (state_q)
                S_IDLE: begin
                    sc_d = '0;
                    // The falling-edge tick is sc=0 of the start bit.
                    if (!rxd_i) begin
                        state_d = S_START;
                        sc_d    = SC_W'(1);
                    end
                end

                S_START: begin
                    if (dec && vote) begin
                        state_d = S_IDLE;     // false start
                        sc_d    = '0;
                    end else if (sc_q == SC_LAST) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end

                S_DATA: begin
                    // LSB arrives first, so shifting in at the MSB side leaves
                    // bit 0 at position 0 after the last data bit.
                    if (dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (sc_q == SC_LAST) begin
                        if (bit_q == BC_LAST) state_d = S_STOP;
                        else                  bit_d   = bit_q + BC_W'(1);
                    end
                end

                S_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is
                    // caught from IDLE.
                    if (dec) begin
                        sc_d = '0;
                        if (vote) begin
                            deliver = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = S_WAIT_IDLE;
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    // Hold off while the line sits low (break) so a stuck-low
                    // line does not produce a stream of frames.
                    sc_d = '0;
                    if (rxd_i) state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                    sc_d    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sc_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            samp_q  <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output holding register and handshake; runs every clock.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err;
            overrun_o   <= 1'b0;
            if (deliver) begin
                // A word accepted this very cycle frees the slot for the new one.
                if (!valid_o || ready_i) begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_framer
//
// Directed and randomized bench for uart_rx_framer (OVERSAMPLE=16,
// DATA_BITS=8, one tick every 4 clocks). Line levels come from a frame-level
// model: tick index i of a frame lies in bit period i/16 (start, data LSB
// first, stop). Accepted words are collected by a monitor and compared with
// the words the model says should arrive.
// ----------------------------------------------------------------------------
module tb_uart_rx_framer;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TOTAL    = OS * (DB + 2);          // ticks per frame
    localparam int DEC_STOP = OS * (DB + 1) + OS / 2 + 1;  // stop decision tick

    typedef struct packed {
        logic          v_pre;   // valid_o just before the stop decision edge
        logic          v_post;  // valid_o one clock after it
        logic [DB-1:0] d_post;
        logic          fe_post;
        logic          ov_post;
        logic          v_acc;   // valid_o two clocks after it
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick_i;
    logic          rxd_i;
    logic          ready_i;
    logic [DB-1:0] data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          overrun_o;
    logic          busy_o;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [DB-1:0] got[$];

    uart_rx_framer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick_i),
        .rxd_i       (rxd_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err_o)        fe_cnt++;
            if (overrun_o)          ov_cnt++;
            if (valid_o && ready_i) got.push_back(data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the edge, then set the inputs for the next cycle.
    task automatic cyc(input logic t, input logic r);
        @(posedge clk);
        #1;
        tick_i = t;
        rxd_i  = r;
    endtask

    task automatic idle_ticks(input int n, input logic lvl);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, lvl);
            cyc(1'b0, lvl);
            cyc(1'b0, lvl);
            cyc(1'b0, lvl);
        end
    endtask

    // Frame model: line level at tick idx of a frame carrying word b.
    function automatic logic line_level(input logic [DB-1:0] b, input logic stop, input int idx);
        int bit_i;
        bit_i = idx / OS;
        if (bit_i == 0)  return 1'b0;
        if (bit_i <= DB) return b[bit_i-1];
        return stop;
    endfunction

    // Drive ticks 0..last of a frame; tick 'glitch' is inverted.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int glitch,
                              input int last, output obs_t o);
        logic lvl;
        logic r;
        o = '0;
        for (int i = 0; i <= last && i < TOTAL; i++) begin
            lvl = line_level(b, stop, i);
            r   = (i == glitch) ? ~lvl : lvl;
            cyc(1'b1, r);
            if (i == DEC_STOP) o.v_pre = valid_o;
            cyc(1'b0, lvl);
            if (i == DEC_STOP) begin
                o.v_post  = valid_o;
                o.d_post  = data_o;
                o.fe_post = frame_err_o;
                o.ov_post = overrun_o;
            end
            cyc(1'b0, lvl);
            if (i == DEC_STOP) o.v_acc = valid_o;
            cyc(1'b0, lvl);
        end
    endtask

    initial begin
        obs_t          o;
        obs_t          o2;
        int            gsz;
        int            fe0;
        int            ov0;
        logic [DB-1:0] b;
        logic          stop;
        int            glitch;
        logic [DB-1:0] exp_q[$];
        int            exp_fe;

        rst_n   = 1'b0;
        tick_i  = 1'b0;
        rxd_i   = 1'b1;
        ready_i = 1'b1;

        // Reset state
        #12;
        check("rst_data",  32'(data_o),      32'h0);
        check("rst_valid", 32'(valid_o),     32'h0);
        check("rst_ferr",  32'(frame_err_o), 32'h0);
        check("rst_ovr",   32'(overrun_o),   32'h0);
        check("rst_busy",  32'(busy_o),      32'h0);
        rst_n = 1'b1;

        // Idle line produces nothing
        idle_ticks(200, 1'b1);
        check("idle_valid", 32'(valid_o),    32'h0);
        check("idle_busy",  32'(busy_o),     32'h0);
        check("idle_got",   32'(got.size()), 32'h0);

        // 0x55 with ready high: valid one clock after the stop decision
        gsz = got.size();
        send_frame(8'h55, 1'b1, -1, TOTAL - 1, o);
        check("f55_vpre",  32'(o.v_pre),  32'h0);
        check("f55_vpost", 32'(o.v_post), 32'h1);
        check("f55_data",  32'(o.d_post), 32'h55);
        check("f55_vacc",  32'(o.v_acc),  32'h0);
        check("f55_cnt",   32'(got.size() - gsz), 32'h1);
        if (got.size() > gsz) check("f55_got", 32'(got[gsz]), 32'h55);
        check("f55_nofe",  32'(fe_cnt), 32'h0);
        check("f55_noov",  32'(ov_cnt), 32'h0);

        // False start: low 5 ticks, back to IDLE at the sc=9 decision
        gsz = got.size();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, (i < 5) ? 1'b0 : 1'b1);
            if (i == 9) check("fs_busy_before", 32'(busy_o), 32'h1);
            cyc(1'b0, 1'b1);
            if (i == 9) check("fs_busy_after", 32'(busy_o), 32'h0);
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b1);
        end
        idle_ticks(20, 1'b1);
        check("fs_valid", 32'(valid_o), 32'h0);
        check("fs_got",   32'(got.size() - gsz), 32'h0);

        // Framing error, then a break held low, then a good frame
        fe0 = fe_cnt;
        gsz = got.size();
        send_frame(8'hA3, 1'b0, -1, TOTAL - 1, o);
        check("fe_pulse", 32'(o.fe_post), 32'h1);
        check("fe_valid", 32'(o.v_post),  32'h0);
        idle_ticks(50, 1'b0);
        check("brk_busy",  32'(busy_o),          32'h1);
        check("brk_fecnt", 32'(fe_cnt - fe0),    32'h1);
        check("brk_valid", 32'(valid_o),         32'h0);
        check("brk_got",   32'(got.size() - gsz), 32'h0);
        idle_ticks(3, 1'b1);
        check("brk_idle", 32'(busy_o), 32'h0);
        send_frame(8'h0F, 1'b1, -1, TOTAL - 1, o);
        check("f0f_vpost", 32'(o.v_post), 32'h1);
        check("f0f_data",  32'(o.d_post), 32'h0F);
        check("f0f_cnt",   32'(got.size() - gsz), 32'h1);
        if (got.size() > gsz) check("f0f_got", 32'(got[gsz]), 32'h0F);

        // Overrun: ready low, two back-to-back frames
        ready_i = 1'b0;
        ov0 = ov_cnt;
        gsz = got.size();
        send_frame(8'h11, 1'b1, -1, TOTAL - 1, o);
        check("ovr_first_v", 32'(o.v_post), 32'h1);
        check("ovr_first_d", 32'(o.d_post), 32'h11);
        send_frame(8'h22, 1'b1, -1, TOTAL - 1, o2);
        check("ovr_pulse",  32'(o2.ov_post), 32'h1);
        check("ovr_held_d", 32'(o2.d_post),  32'h11);
        check("ovr_held_v", 32'(o2.v_post),  32'h1);
        check("ovr_cnt",    32'(ov_cnt - ov0), 32'h1);
        ready_i = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check("ovr_acc_v", 32'(valid_o), 32'h0);
        check("ovr_acc_n", 32'(got.size() - gsz), 32'h1);
        if (got.size() > gsz) check("ovr_acc_d", 32'(got[gsz]), 32'h11);

        // Glitch at sc=8 of data bit 3 is out-voted; word left pending
        ready_i = 1'b0;
        send_frame(8'hC6, 1'b1, OS * 4 + 8, TOTAL - 1, o);
        check("gl_valid", 32'(o.v_post), 32'h1);
        check("gl_data",  32'(o.d_post), 32'hC6);

        // Reset during data bit 4 clears everything at once
        send_frame(8'h99, 1'b1, -1, OS * 5 + 4, o);
        rst_n = 1'b0;
        #1;
        check("mrst_data",  32'(data_o),      32'h0);
        check("mrst_valid", 32'(valid_o),     32'h0);
        check("mrst_busy",  32'(busy_o),      32'h0);
        check("mrst_ferr",  32'(frame_err_o), 32'h0);
        check("mrst_ovr",   32'(overrun_o),   32'h0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        idle_ticks(5, 1'b1);
        gsz = got.size();
        send_frame(8'h7E, 1'b1, -1, TOTAL - 1, o);
        check("f7e_data", 32'(o.d_post), 32'h7E);
        check("f7e_cnt",  32'(got.size() - gsz), 32'h1);
        if (got.size() > gsz) check("f7e_got", 32'(got[gsz]), 32'h7E);

        // Randomized frames: random data, random stop errors, a random
        // single-tick glitch at one sample point of one data bit.
        gsz    = got.size();
        fe0    = fe_cnt;
        exp_fe = 0;
        for (int k = 0; k < 8; k++) begin
            b      = DB'($urandom);
            stop   = ($urandom_range(0, 3) != 0);
            glitch = OS * (1 + int'($urandom_range(0, DB - 1))) + int'($urandom_range(7, 9));
            idle_ticks(int'($urandom_range(1, 12)), 1'b1);
            send_frame(b, stop, glitch, TOTAL - 1, o);
            if (stop) exp_q.push_back(b);
            else      exp_fe++;
            check("rnd_vpost", 32'(o.v_post), 32'(stop));
            if (stop) check("rnd_data", 32'(o.d_post), 32'(b));
        end
        idle_ticks(2, 1'b1);
        check("rnd_count", 32'(got.size() - gsz), 32'(exp_q.size()));
        check("rnd_fecnt", 32'(fe_cnt - fe0), 32'(exp_fe));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (gsz + k < got.size()) check("rnd_word", 32'(got[gsz + k]), 32'(exp_q[k]));
        end
        check("end_ovcnt", 32'(ov_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
